// File: rtl/ball_engine.sv
// ball_engine: owns the ball for the game core. Tracks position and direction,
// bounces off walls and paddles, detects misses, keeps score and sequences the
// serve countdown and game-over. All motion advances only on the frame tick.
module ball_engine #(
    parameter int unsigned SCREEN_W    = 640,
    parameter int unsigned SCREEN_H    = 480,
    parameter int unsigned BALL_SZ     = 10,
    parameter int unsigned PAD_W       = 10,
    parameter int unsigned PAD_H       = 50,
    parameter int unsigned P1_X        = 20,
    parameter int unsigned P2_X        = 620,
    parameter int unsigned STEP        = 2,
    parameter int unsigned SERVE_TICKS = 60,
    parameter int unsigned WIN_SCORE   = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        start,
    input  logic [9:0]  p1Pos,
    input  logic [9:0]  p2Pos,
    output logic [10:0] ballX,
    output logic [9:0]  ballY,
    output logic        dirX,
    output logic [3:0]  score1,
    output logic [3:0]  score2,
    output logic        pointPulse,
    output logic        gameOver
);

    localparam logic [10:0] CenterX  = 11'((SCREEN_W - BALL_SZ) / 2);
    localparam logic [9:0]  CenterY  = 10'((SCREEN_H - BALL_SZ) / 2);
    // 12-bit copies so every sum and compare below has headroom and never wraps.
    localparam logic [11:0] Step12   = 12'(STEP);
    localparam logic [11:0] Ball12   = 12'(BALL_SZ);
    localparam logic [11:0] PadH12   = 12'(PAD_H);
    localparam logic [11:0] ScrW12   = 12'(SCREEN_W);
    localparam logic [11:0] ScrH12   = 12'(SCREEN_H);
    localparam logic [11:0] P1Face12 = 12'(P1_X + PAD_W);
    localparam logic [11:0] P2Face12 = 12'(P2_X);
    localparam logic [11:0] P2Stop12 = 12'(P2_X - BALL_SZ);
    localparam logic [11:0] YMax12   = 12'(SCREEN_H - BALL_SZ);
    localparam logic [15:0] ServeLast = 16'(SERVE_TICKS - 1);
    localparam logic [3:0]  WinScore  = 4'(WIN_SCORE);

    typedef enum logic [2:0] {StIdle, StServe, StMove, StPoint, StOver} state_e;

    state_e      state_q, state_d;
    logic [10:0] ball_x_q, ball_x_d;
    logic [9:0]  ball_y_q, ball_y_d;
    logic        dir_x_q, dir_x_d;
    logic        dir_y_q, dir_y_d;
    logic [3:0]  score1_q, score1_d;
    logic [3:0]  score2_q, score2_d;
    logic [15:0] serve_cnt_q, serve_cnt_d;
    logic        point_pulse_q, point_pulse_d;
    logic        game_over_q, game_over_d;
    logic        scorer_q, scorer_d;  // 1: right player scored

    logic [11:0] x_w, y_w, p1_w, p2_w;
    logic [11:0] x_next, y_next;
    logic        dy_next;
    logic        overlap1, overlap2;
    logic        hit_l, hit_r, miss_l, miss_r;
    logic [3:0]  score_inc;

    // Collision, miss and wall-bounce evaluation on the current ball position.
    always_comb begin
        x_w  = {1'b0, ball_x_q};
        y_w  = {2'b0, ball_y_q};
        p1_w = {2'b0, p1Pos};
        p2_w = {2'b0, p2Pos};

        overlap1 = (y_w + Ball12 > p1_w) && (y_w < p1_w + PadH12);
        overlap2 = (y_w + Ball12 > p2_w) && (y_w < p2_w + PadH12);

        // Left hit written as x <= face+STEP so no subtraction is needed.
        hit_l  = !dir_x_q && (x_w >= P1Face12) && (x_w <= P1Face12 + Step12) && overlap1;
        hit_r  = dir_x_q && (x_w + Ball12 <= P2Face12) &&
                 (x_w + Ball12 + Step12 >= P2Face12) && overlap2;
        miss_l = !dir_x_q && !hit_l && (x_w < Step12);
        miss_r = dir_x_q && !hit_r && (x_w + Ball12 + Step12 > ScrW12);

        y_next  = y_w;
        dy_next = dir_y_q;
        if (dir_y_q) begin
            if (y_w + Ball12 + Step12 >= ScrH12) begin
                y_next  = YMax12;
                dy_next = 1'b0;
            end else begin
                y_next = y_w + Step12;
            end
        end else begin
            if (y_w < Step12) begin
                y_next  = '0;
                dy_next = 1'b1;
            end else begin
                y_next = y_w - Step12;
            end
        end

        if (hit_l) begin
            x_next = P1Face12;
        end else if (hit_r) begin
            x_next = P2Stop12;
        end else if (dir_x_q) begin
            x_next = x_w + Step12;
        end else if (!miss_l) begin
            x_next = x_w - Step12;
        end else begin
            x_next = x_w;
        end
    end

    // Game sequencing: next-state and next values for every register.
    always_comb begin
        state_d       = state_q;
        ball_x_d      = ball_x_q;
        ball_y_d      = ball_y_q;
        dir_x_d       = dir_x_q;
        dir_y_d       = dir_y_q;
        score1_d      = score1_q;
        score2_d      = score2_q;
        serve_cnt_d   = serve_cnt_q;
        scorer_d      = scorer_q;
        point_pulse_d = 1'b0;
        score_inc     = scorer_q ? score2_q + 4'd1 : score1_q + 4'd1;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    serve_cnt_d = '0;
                    state_d     = StServe;
                end
            end
            StServe: begin
                if (tick) begin
                    if (serve_cnt_q == ServeLast) begin
                        state_d = StMove;
                    end else begin
                        serve_cnt_d = serve_cnt_q + 16'd1;
                    end
                end
            end
            StMove: begin
                if (tick) begin
                    if (miss_l || miss_r) begin
                        // Ball stays frozen where it left the field.
                        scorer_d = miss_l;
                        state_d  = StPoint;
                    end else begin
                        ball_x_d = x_next[10:0];
                        ball_y_d = y_next[9:0];
                        dir_y_d  = dy_next;
                        if (hit_l) dir_x_d = 1'b1;
                        if (hit_r) dir_x_d = 1'b0;
                    end
                end
            end
            StPoint: begin
                point_pulse_d = 1'b1;
                ball_x_d      = CenterX;
                ball_y_d      = CenterY;
                // Serve toward whoever conceded.
                dir_x_d       = !scorer_q;
                if (scorer_q) score2_d = score_inc;
                else          score1_d = score_inc;
                if (score_inc == WinScore) begin
                    state_d = StOver;
                end else begin
                    serve_cnt_d = '0;
                    state_d     = StServe;
                end
            end
            StOver: begin
                if (start) begin
                    score1_d    = '0;
                    score2_d    = '0;
                    dir_x_d     = 1'b1;
                    serve_cnt_d = '0;
                    state_d     = StServe;
                end
            end
            default: state_d = StIdle;
        endcase

        game_over_d = (state_d == StOver);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            ball_x_q      <= CenterX;
            ball_y_q      <= CenterY;
            dir_x_q       <= 1'b1;
            dir_y_q       <= 1'b1;
            score1_q      <= '0;
            score2_q      <= '0;
            serve_cnt_q   <= '0;
            scorer_q      <= 1'b0;
            point_pulse_q <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ball_x_q      <= ball_x_d;
            ball_y_q      <= ball_y_d;
            dir_x_q       <= dir_x_d;
            dir_y_q       <= dir_y_d;
            score1_q      <= score1_d;
            score2_q      <= score2_d;
            serve_cnt_q   <= serve_cnt_d;
            scorer_q      <= scorer_d;
            point_pulse_q <= point_pulse_d;
            game_over_q   <= game_over_d;
        end
    end

    assign ballX      = ball_x_q;
    assign ballY      = ball_y_q;
    assign dirX       = dir_x_q;
    assign score1     = score1_q;
    assign score2     = score2_q;
    assign pointPulse = point_pulse_q;
    assign gameOver   = game_over_q;

endmodule

// File: tb/tb_ball_engine.sv
// tb_ball_engine: randomized play against a behavioural model of the game
// rules, including mid-rally and mid-point resets.
module tb_ball_engine;

    localparam int W = 640, H = 480, B = 10, PH = 50, P1F = 30, P2L = 620;
    localparam int ST = 2, SERVE = 60, WIN = 9;
    localparam int CX = 315, CY = 235;
    localparam int NCYC = 40000;

    logic        clk = 1'b0;
    logic        reset, tick, start;
    logic [9:0]  p1Pos, p2Pos;
    logic [10:0] ballX;
    logic [9:0]  ballY;
    logic        dirX, pointPulse, gameOver;
    logic [3:0]  score1, score2;

    ball_engine dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .start      (start),
        .p1Pos      (p1Pos),
        .p2Pos      (p2Pos),
        .ballX      (ballX),
        .ballY      (ballY),
        .dirX       (dirX),
        .score1     (score1),
        .score2     (score2),
        .pointPulse (pointPulse),
        .gameOver   (gameOver)
    );

    always #5 clk = ~clk;

    int n_total = 0, n_bad = 0;

    // Model: position, direction, score, plus "ticks of serve left" and a
    // pending scorer (0 none, 1 left player, 2 right player).
    int m_x, m_y, m_dx, m_dy, m_s1, m_s2, m_pulse, m_over, m_idle, m_hold, m_pend;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_x = CX; m_y = CY; m_dx = 1; m_dy = 1; m_s1 = 0; m_s2 = 0;
        m_pulse = 0; m_over = 0; m_idle = 1; m_hold = 0; m_pend = 0;
    endtask

    task automatic model_move();
        int ny, ndy, nx, ndx, miss, p1, p2;
        bit ov1, ov2;
        p1 = int'(p1Pos); p2 = int'(p2Pos);
        ov1 = (m_y + B > p1) && (m_y < p1 + PH);
        ov2 = (m_y + B > p2) && (m_y < p2 + PH);
        ndy = m_dy; ndx = m_dx; miss = 0; nx = m_x;
        if (m_dy == 1) begin
            ny = m_y + ST;
            if (ny + B >= H) begin ny = H - B; ndy = 0; end
        end else begin
            ny = m_y - ST;
            if (ny < 0) begin ny = 0; ndy = 1; end
        end
        if (m_dx == 0) begin
            if (m_x >= P1F && m_x - ST <= P1F && ov1) begin nx = P1F; ndx = 1; end
            else if (m_x - ST < 0) miss = 2;
            else nx = m_x - ST;
        end else begin
            if (m_x + B <= P2L && m_x + B + ST >= P2L && ov2) begin nx = P2L - B; ndx = 0; end
            else if (m_x + B + ST > W) miss = 1;
            else nx = m_x + ST;
        end
        if (miss != 0) m_pend = miss;
        else begin m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy; end
    endtask

    task automatic model_step();
        if (reset) begin model_reset(); return; end
        m_pulse = 0;
        if (m_pend != 0) begin
            if (m_pend == 1) m_s1++; else m_s2++;
            m_pulse = 1; m_x = CX; m_y = CY;
            m_dx = (m_pend == 2) ? 0 : 1;
            if (m_s1 == WIN || m_s2 == WIN) m_over = 1;
            else m_hold = SERVE;
            m_pend = 0;
        end else if (m_idle == 1 || m_over == 1) begin
            if (start) begin
                if (m_over == 1) begin m_s1 = 0; m_s2 = 0; m_dx = 1; end
                m_idle = 0; m_over = 0; m_hold = SERVE;
            end
        end else if (tick) begin
            if (m_hold > 0) m_hold--;
            else model_move();
        end
    endtask

    function automatic int track(input int y);
        int t;
        t = y + 9 - int'($urandom_range(0, 60));
        if (t < 0) t = 0;
        if (t > H - PH) t = H - PH;
        return t;
    endfunction

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_x"}, int'(ballX), CX);
        check_eq({tag, "_y"}, int'(ballY), CY);
        check_eq({tag, "_dir"}, int'(dirX), 1);
        check_eq({tag, "_s1"}, int'(score1), 0);
        check_eq({tag, "_s2"}, int'(score2), 0);
        check_eq({tag, "_pulse"}, int'(pointPulse), 0);
        check_eq({tag, "_over"}, int'(gameOver), 0);
    endtask

    initial begin
        int n_over = 0, n_pulse = 0;
        bit prev_over = 0, pt_reset_done = 0;
        reset = 1'b1; tick = 1'b0; start = 1'b0; p1Pos = '0; p2Pos = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values("init");
        reset = 1'b0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_eq("ballX", int'(ballX), m_x);
            check_eq("ballY", int'(ballY), m_y);
            check_eq("dirX", int'(dirX), m_dx);
            check_eq("score1", int'(score1), m_s1);
            check_eq("score2", int'(score2), m_s2);
            check_eq("pointPulse", int'(pointPulse), m_pulse);
            check_eq("gameOver", int'(gameOver), m_over);
            if (gameOver && !prev_over) n_over++;
            if (pointPulse) n_pulse++;
            prev_over = gameOver;

            tick  = ($urandom_range(0, 3) != 0);
            start = ($urandom_range(0, 15) == 0);
            p1Pos = ($urandom_range(0, 9) < 4) ? 10'(track(m_y)) : 10'($urandom_range(0, 430));
            p2Pos = ($urandom_range(0, 9) < 4) ? 10'(track(m_y)) : 10'($urandom_range(0, 430));

            if (cyc == 2000 || (cyc > 25000 && m_pend != 0 && !pt_reset_done)) begin
                if (cyc != 2000) pt_reset_done = 1;
                reset = 1'b1;
                #1;
                check_reset_values(cyc == 2000 ? "rst_run" : "rst_point");
            end else begin
                reset = 1'b0;
            end
        end

        check_eq("reached_game_over", int'(n_over > 0), 1);
        check_eq("saw_points", int'(n_pulse > 0), 1);
        check_eq("reset_in_point", int'(pt_reset_done), 1);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
